// File: rtl/machina_pkg.sv
// Shared types, fixed-point constants and saturation helper for the machina neuron datapath.
package machina_pkg;

    typedef logic [7:0]         activation_t;
    typedef logic signed [15:0] argument_t;
    typedef logic signed [15:0] delta_t;

    localparam int        FRAC_BITS = 8;
    localparam argument_t ARG_MAX   = 16'h7FFF;
    localparam argument_t ARG_MIN   = 16'h8000;

    // Clamp a 32-bit signed value into the signed Q8.8 range.
    function automatic argument_t sat16(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return ARG_MAX;
        end
        if (value < -32'sd32768) begin
            return ARG_MIN;
        end
        return value[15:0];
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered signed 16 x unsigned 8 multiply-accumulate; the product is also exposed
// combinationally so the weight update can reuse the same multiplier.
module neuron_mac
    import machina_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic signed [31:0] load_value,
    input  logic               accumulate,
    input  argument_t          operand_a,
    input  activation_t        operand_b,
    output logic signed [23:0] product,
    output logic signed [31:0] acc
);

    assign product = 24'(operand_a * $signed({1'b0, operand_b}));

    // Accumulator register: load wins over accumulate, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_value;
        end else if (accumulate) begin
            acc <= acc + 32'(product);
        end
    end

endmodule

// File: rtl/neuron.sv
// Single neuron: serial weighted sum plus bias, streamed to the logistic stage,
// followed in train mode by a shift-scaled gradient update of weights and bias.
module neuron
    import machina_pkg::*;
#(
    parameter int N          = 4,
    parameter int RATE_SHIFT = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           train,
    input  logic           input_valid,
    input  logic [N*8-1:0] input_data,
    output logic           input_ready,
    output logic           argument_valid,
    output logic [15:0]    argument_data,
    input  logic           argument_ready,
    input  logic           delta_valid,
    input  logic [15:0]    delta_data,
    output logic           delta_ready
);

    localparam int IW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, ACCUM, ARGUMENT, DELTA, UPDATE} state_t;

    state_t             state;
    state_t             state_next;
    argument_t          weight [N];
    argument_t          bias;
    activation_t        x_lat [N];
    logic               train_lat;
    delta_t             delta_lat;
    logic [IW-1:0]      index;

    argument_t          sel_weight;
    activation_t        sel_x;
    argument_t          mac_a;
    logic               mac_load;
    logic               mac_accumulate;
    logic signed [23:0] mac_product;
    logic signed [31:0] acc;
    argument_t          weight_next;
    argument_t          bias_next;

    // Pick the weight and activation addressed by the shared index.
    always_comb begin
        sel_weight = '0;
        sel_x      = '0;
        for (int i = 0; i < N; i++) begin
            if (index == IW'(i)) begin
                sel_weight = weight[i];
                sel_x      = x_lat[i];
            end
        end
    end

    assign mac_a          = (state == UPDATE) ? delta_lat : sel_weight;
    assign mac_load       = (state == IDLE) && input_valid;
    assign mac_accumulate = (state == ACCUM);

    neuron_mac u_mac (
        .clock      (clock),
        .reset      (reset),
        .load       (mac_load),
        .load_value ({{8{bias[15]}}, bias, 8'h00}),
        .accumulate (mac_accumulate),
        .operand_a  (mac_a),
        .operand_b  (sel_x),
        .product    (mac_product),
        .acc        (acc)
    );

    assign weight_next   = sat16(32'(sel_weight) + (32'(mac_product) >>> (FRAC_BITS + RATE_SHIFT)));
    assign bias_next     = sat16(32'(bias) + 32'(delta_lat >>> RATE_SHIFT));
    assign argument_data = sat16(acc >>> FRAC_BITS);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; readies depend only on state, never on valids.
    always_comb begin
        state_next     = state;
        input_ready    = 1'b0;
        argument_valid = 1'b0;
        delta_ready    = 1'b0;
        case (state)
            IDLE: begin
                input_ready = !reset;
                if (input_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (index == IW'(N - 1)) begin
                    state_next = ARGUMENT;
                end
            end
            ARGUMENT: begin
                argument_valid = 1'b1;
                if (argument_ready) begin
                    state_next = train_lat ? DELTA : IDLE;
                end
            end
            DELTA: begin
                delta_ready = 1'b1;
                if (delta_valid) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (index == IW'(N)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: input latch, index walk, weight and bias updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                weight[i] <= '0;
                x_lat[i]  <= '0;
            end
            bias      <= '0;
            train_lat <= 1'b0;
            delta_lat <= '0;
            index     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        for (int i = 0; i < N; i++) begin
                            x_lat[i] <= input_data[8*i +: 8];
                        end
                        train_lat <= train;
                        index     <= '0;
                    end
                end
                ACCUM: begin
                    index <= index + 1'b1;
                end
                DELTA: begin
                    if (delta_valid) begin
                        delta_lat <= delta_data;
                        index     <= '0;
                    end
                end
                UPDATE: begin
                    if (index == IW'(N)) begin
                        bias <= bias_next;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (index == IW'(i)) begin
                                weight[i] <= weight_next;
                            end
                        end
                    end
                    index <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: vector table with a scoreboard of expected arguments,
// a reference model of the weights/bias, and hand-written reset and backpressure sequences.
module tb_neuron;

    localparam int N          = 4;
    localparam int RATE_SHIFT = 0;

    logic           clock = 1'b0;
    logic           reset;
    logic           train;
    logic           input_valid;
    logic [N*8-1:0] input_data;
    logic           input_ready;
    logic           argument_valid;
    logic [15:0]    argument_data;
    logic           argument_ready;
    logic           delta_valid;
    logic [15:0]    delta_data;
    logic           delta_ready;

    int checks = 0;
    int errors = 0;

    int          model_w [N];
    int          model_bias;
    logic [15:0] exp_q [$];

    typedef struct {
        logic [N*8-1:0] x;
        logic           tr;
        logic [15:0]    delta;
        int             stall;
        logic           early;
        int             exp_arg;
    } vec_t;

    vec_t vecs [11];

    always #5 clock = ~clock;

    neuron #(.N(N), .RATE_SHIFT(RATE_SHIFT)) dut (
        .clock          (clock),
        .reset          (reset),
        .train          (train),
        .input_valid    (input_valid),
        .input_data     (input_data),
        .input_ready    (input_ready),
        .argument_valid (argument_valid),
        .argument_data  (argument_data),
        .argument_ready (argument_ready),
        .delta_valid    (delta_valid),
        .delta_data     (delta_data),
        .delta_ready    (delta_ready)
    );

    function automatic int msat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int model_arg(input logic [N*8-1:0] x);
        int acc;
        acc = model_bias * 256;
        for (int i = 0; i < N; i++) acc += model_w[i] * int'(x[8*i +: 8]);
        return msat(acc >>> 8);
    endfunction

    function automatic void model_update(input logic [N*8-1:0] x, input logic [15:0] d);
        int dv;
        dv = int'($signed(d));
        for (int i = 0; i < N; i++)
            model_w[i] = msat(model_w[i] + ((dv * int'(x[8*i +: 8])) >>> (8 + RATE_SHIFT)));
        model_bias = msat(model_bias + (dv >>> RATE_SHIFT));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) model_w[i] = 0;
        model_bias = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // At most one of the three handshake signals may be high in any cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checkOutput("one_hot_handshake",
                        16'(int'(input_ready) + int'(argument_valid) + int'(delta_ready) > 1), 16'd0);
        end
    end

    task automatic applyStimulus(input vec_t v);
        int          cnt;
        int          model_val;
        logic [15:0] held;
        cnt = 0;
        while (!input_ready && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        if (!input_ready) begin
            checkOutput("input_ready_wait", 16'(input_ready), 16'd1);
            return;
        end
        input_valid = 1'b1;
        input_data  = v.x;
        train       = v.tr;
        model_val   = model_arg(v.x);
        exp_q.push_back((v.exp_arg >= 0) ? 16'(v.exp_arg) : 16'(model_val));
        @(negedge clock);
        input_valid = 1'b0;
        train       = ~v.tr;
        input_data  = ~v.x;
        cnt = 1;
        while (!argument_valid && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("arg_latency", 16'(cnt), 16'(N + 1));
        if (!argument_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        held = argument_data;
        for (int s = 0; s < v.stall; s++) begin
            delta_valid = v.early;
            delta_data  = 16'hDEAD;
            @(negedge clock);
            checkOutput("arg_hold", argument_data, held);
            checkOutput("arg_valid_stall", 16'(argument_valid), 16'd1);
            checkOutput("in_ready_stall", 16'(input_ready), 16'd0);
        end
        delta_valid    = 1'b0;
        argument_ready = 1'b1;
        checkOutput("arg_data", argument_data, exp_q.pop_front());
        @(negedge clock);
        argument_ready = 1'b0;
        if (v.tr) begin
            checkOutput("delta_ready", 16'(delta_ready), 16'd1);
            delta_valid = 1'b1;
            delta_data  = v.delta;
            model_update(v.x, v.delta);
            @(negedge clock);
            delta_valid = 1'b0;
            cnt = 1;
            while (!input_ready && cnt < 50) begin
                @(negedge clock);
                cnt++;
            end
            checkOutput("update_len", 16'(cnt), 16'(N + 2));
        end else begin
            checkOutput("ready_after_arg", 16'(input_ready), 16'd1);
        end
    endtask

    task automatic resetMidAccum();
        int cnt;
        cnt = 0;
        while (!input_ready && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        input_valid = 1'b1;
        input_data  = 32'h0000_00FF;
        train       = 1'b1;
        @(negedge clock);
        input_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_arg_valid", 16'(argument_valid), 16'd0);
        checkOutput("rst_delta_ready", 16'(delta_ready), 16'd0);
        checkOutput("rst_input_ready", 16'(input_ready), 16'd0);
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        @(negedge clock);
        checkOutput("post_rst_ready", 16'(input_ready), 16'd1);
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vecs[0]  = '{x: 32'h0000_0000, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: 16'h0000};
        vecs[1]  = '{x: 32'h0000_0080, tr: 1'b1, delta: 16'h0100, stall: 0, early: 1'b0, exp_arg: 16'h0000};
        vecs[2]  = '{x: 32'h0000_0080, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: 16'h0140};
        vecs[3]  = '{x: 32'hFFFF_FFFF, tr: 1'b1, delta: 16'h7FFF, stall: 5, early: 1'b1, exp_arg: 16'h017F};
        vecs[4]  = '{x: 32'hFFFF_FFFF, tr: 1'b1, delta: 16'h7FFF, stall: 0, early: 1'b0, exp_arg: -1};
        vecs[5]  = '{x: 32'hFFFF_FFFF, tr: 1'b0, delta: 16'h0000, stall: 2, early: 1'b0, exp_arg: 16'h7FFF};
        vecs[6]  = '{x: 32'hFFFF_FFFF, tr: 1'b1, delta: 16'h8000, stall: 0, early: 1'b0, exp_arg: -1};
        vecs[7]  = '{x: 32'hFFFF_FFFF, tr: 1'b1, delta: 16'h8000, stall: 0, early: 1'b0, exp_arg: -1};
        vecs[8]  = '{x: 32'hFFFF_FFFF, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: 16'h8000};
        vecs[9]  = '{x: 32'h1020_3040, tr: 1'b1, delta: 16'hFE00, stall: 1, early: 1'b1, exp_arg: -1};
        vecs[10] = '{x: 32'h1020_3040, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: -1};

        reset          = 1'b1;
        train          = 1'b0;
        input_valid    = 1'b0;
        input_data     = '0;
        argument_ready = 1'b0;
        delta_valid    = 1'b0;
        delta_data     = '0;
        model_clear();
        repeat (2) @(negedge clock);
        checkOutput("reset_input_ready", 16'(input_ready), 16'd0);
        checkOutput("reset_arg_valid", 16'(argument_valid), 16'd0);
        checkOutput("reset_delta_ready", 16'(delta_ready), 16'd0);
        checkOutput("reset_arg_data", argument_data, 16'h0000);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("first_ready", 16'(input_ready), 16'd1);

        for (int k = 0; k < 11; k++) applyStimulus(vecs[k]);

        resetMidAccum();
        applyStimulus('{x: 32'h0000_0080, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: 16'h0000});
        applyStimulus('{x: 32'h0000_0080, tr: 1'b1, delta: 16'hFE00, stall: 0, early: 1'b0, exp_arg: -1});
        applyStimulus('{x: 32'h4000_0080, tr: 1'b0, delta: 16'h0000, stall: 0, early: 1'b0, exp_arg: -1});

        $display("[TB] done, scoreboard entries left %0d", exp_q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron.md
Name: neuron

Overview:
- Upstream neighbour of the logistic activation stage.
- Accepts a vector of N unsigned Q0.8 activations and computes a saturated Q8.8 weighted sum plus bias, one MAC per cycle. It streams that sum out as the 16-bit logistic argument.
- In train mode it then consumes the 16-bit Q8.8 delta returned by the logistic stage and applies a shift-scaled gradient update to its weights and bias.

Parameters:
N, 4, number of inputs/weights (N >= 1)
RATE_SHIFT, 0, learning-rate right shift applied to every update term (0..8)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
train  input  1  training mode; sampled on input acceptance
input_valid  input  1  input vector valid
input_data  input  N*8  activations, element i at bits [8i+7:8i], unsigned Q0.8
input_ready  output  1  input vector accepted when valid && ready
argument_valid  output  1  weighted sum valid
argument_data  output  16  weighted sum, signed Q8.8
argument_ready  input  1  downstream accepts argument
delta_valid  input  1  delta valid
delta_data  input  16  delta, signed Q8.8
delta_ready  output  1  delta accepted when valid && ready

Behaviour:
- Clocking and reset: single clock domain.
  - Reset is synchronous and active-high; it overrides all other activity, including mid-operation.
  - Reset state: state=IDLE; input_ready=0 during reset and 1 on the first cycle after; argument_valid=0; delta_ready=0; argument_data=0; all weights=0; bias=0; latched train=0.
- States: IDLE, ACCUM, ARGUMENT, DELTA, UPDATE.
  - IDLE: input_ready=1. On input_valid: latch input vector and train, load acc = sign-extended bias<<8, index=0, go to ACCUM.
  - ACCUM: one cycle per index 0..N-1.
    - acc += w[index]*x[index]; the product is signed 16 x unsigned 8, Q8.16, 24 bits; the accumulator is 32-bit signed.
    - After index N-1, go to ARGUMENT.
  - ARGUMENT: argument_valid=1; argument_data = acc[23:8] saturated to [0x8000, 0x7FFF] when acc exceeds 16-bit Q8.8 range.
    - argument_valid is first high N+1 cycles after the acceptance edge.
    - data is held stable while argument_ready=0.
    - On handshake: go to DELTA if latched train=1, else IDLE (input_ready=1 the following cycle).
  - DELTA: delta_ready=1. On delta_valid: latch delta, index=0, go to UPDATE. Waits indefinitely.
  - UPDATE: one cycle per index 0..N-1, then one bias cycle, then IDLE.
    - Weight cycle: w[i] <= sat16(w[i] + ((delta*x[i]) >>> (8+RATE_SHIFT))).
    - Bias cycle: bias <= sat16(bias + (delta >>> RATE_SHIFT)).
    - Shifts are arithmetic; sat16 clamps to [0x8000, 0x7FFF].
- Throughput: inference 1 vector per N+2 cycles with argument_ready tied high; training adds ≥N+2 cycles.
- Handshake rules:
  - No combinational path from any valid to any ready.
  - Only one of input_ready/argument_valid/delta_ready is high in any cycle.
  - The train pin changing mid-operation has no effect.
  - delta_valid asserted outside DELTA is ignored until DELTA is entered.
- Reset mid-operation: in-flight vector discarded; weights and bias cleared.

Decomposition:
- Shared package machina_pkg provides:
  - activation_t (logic [7:0], Q0.8), argument_t and delta_t (logic signed [15:0], Q8.8), constants FRAC_BITS=8, ARG_MAX=16'h7FFF, ARG_MIN=16'h8000;
  - function sat16 (32-bit signed to argument_t saturation).
- One natural sub-module: neuron_mac. It holds a registered signed 16x8 multiply-accumulate with clear/load, and is shared by ACCUM (acc += w*x) and UPDATE (product for the gradient term).
- The FSM, weight register file and bias stay in neuron.

Test Plan:
- Reset, then inference x={0,0,0,0}, train=0 -> argument_data=0x0000 exactly N+1 cycles after acceptance; input_ready returns 1 next cycle after handshake.
- train=1, x={0x80,0,0,0}, delta=0x0100, RATE_SHIFT=0 -> w0=0x0080 and bias=0x0100; then inference with the same x -> argument_data=0x0140.
- Saturation:
  - train=1 with x={0xFF,0xFF,0xFF,0xFF}, delta=0x7FFF, twice -> bias=0x7FFF (clamped);
  - then inference with the same x -> argument_data=0x7FFF;
  - repeat the sequence with delta=0x8000 -> bias and argument_data clamp to 0x8000.
- Backpressure: argument_ready held 0 for 5 cycles -> argument_valid=1 with data stable; input_ready=0 throughout; delta_valid asserted early is not accepted before DELTA.
- Reset asserted during ACCUM (index 2) -> next cycle argument_valid=0 and delta_ready=0; input_ready=1 the cycle after reset deasserts; inference x={0x80,0,0,0} -> 0x0000 (weights cleared).
- End-to-end with the logistic stage:
  - argument 0x0000 -> activation 0x80;
  - train run with feedback 0xFE00 -> delta_data accepted and update completes in N+1 cycles;
  - input_ready=1 afterwards.
